// File: rtl/redmule_mx_fp16_packer.sv
// Packs the decoder's scalar FP16 stream into DATA_W-wide beats.
// One fill register (per-lane instances) plus one output register give two beats of buffering.

module redmule_mx_fp16_packer_lane #(
  parameter int BITW = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            we_i,
  input  logic            keep_i,
  input  logic [BITW-1:0] din_i,
  output logic [BITW-1:0] beat_o
);

  logic [BITW-1:0] fill_d, fill_q;

  // beat_o bypasses the incoming element so the last lane can load the output on its own handshake edge
  always_comb begin
    fill_d = we_i ? din_i : fill_q;
    beat_o = keep_i ? fill_d : '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) fill_q <= '0;
    else         fill_q <= fill_d;
  end

endmodule

module redmule_mx_fp16_packer #(
  parameter int DATA_W = 256,
  parameter int BITW   = 16,
  parameter int ELEMS  = DATA_W / BITW
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              fp16_valid_i,
  output logic              fp16_ready_o,
  input  logic [BITW-1:0]   fp16_data_i,
  input  logic              flush_i,
  output logic              beat_valid_o,
  input  logic              beat_ready_i,
  output logic [DATA_W-1:0] beat_data_o,
  output logic [ELEMS-1:0]  beat_strb_o
);

  localparam int            CW       = $clog2(ELEMS + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(ELEMS);
  localparam logic [CW-1:0] CNT_LAST = CW'(ELEMS - 1);

  logic [CW-1:0]     cnt_d, cnt_q;
  logic              flush_pending_d, flush_pending_q;
  logic              out_valid_d, out_valid_q;
  logic [DATA_W-1:0] beat_data_d, beat_data_q;
  logic [ELEMS-1:0]  beat_strb_d, beat_strb_q;

  logic slot_free, accept, full_xfer, flush_xfer, load;
  logic [ELEMS-1:0]            lane_we, lane_keep;
  logic [ELEMS-1:0][BITW-1:0]  lane_beat;

  assign slot_free    = !out_valid_q || beat_ready_i;
  assign fp16_ready_o = rst_ni && (cnt_q < CNT_FULL) && !flush_pending_q;
  assign accept       = fp16_valid_i && fp16_ready_o;

  // A pending flush blocks input, so flush_xfer never coincides with an accept
  assign full_xfer  = slot_free && ((accept && (cnt_q == CNT_LAST)) || (cnt_q == CNT_FULL));
  assign flush_xfer = slot_free && flush_pending_q && (cnt_q != '0) && (cnt_q != CNT_FULL);
  assign load       = full_xfer || flush_xfer;

  always_comb begin
    lane_we   = '0;
    lane_keep = '0;
    for (int k = 0; k < ELEMS; k++) begin
      lane_we[k]   = accept && (cnt_q == CW'(k));
      lane_keep[k] = !flush_xfer || (CW'(k) < cnt_q);
    end
  end

  for (genvar k = 0; k < ELEMS; k++) begin : g_lane
    redmule_mx_fp16_packer_lane #(
      .BITW (BITW)
    ) u_lane (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .we_i   (lane_we[k]),
      .keep_i (lane_keep[k]),
      .din_i  (fp16_data_i),
      .beat_o (lane_beat[k])
    );
  end

  always_comb begin
    cnt_d = cnt_q;
    if (load)        cnt_d = '0;
    else if (accept) cnt_d = (cnt_q == CNT_LAST) ? CNT_FULL : cnt_q + CW'(1);
  end

  // A flush arriving while one is already pending is absorbed; clearing wins
  always_comb begin
    flush_pending_d = flush_pending_q;
    if (flush_pending_q) begin
      if (flush_xfer || (cnt_q == '0)) flush_pending_d = 1'b0;
    end else if (flush_i) begin
      flush_pending_d = 1'b1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q && !beat_ready_i;
    beat_data_d = beat_data_q;
    beat_strb_d = beat_strb_q;
    if (load) begin
      out_valid_d = 1'b1;
      beat_data_d = lane_beat;
      beat_strb_d = lane_keep;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q           <= '0;
      flush_pending_q <= 1'b0;
      out_valid_q     <= 1'b0;
      beat_data_q     <= '0;
      beat_strb_q     <= '0;
    end else begin
      cnt_q           <= cnt_d;
      flush_pending_q <= flush_pending_d;
      out_valid_q     <= out_valid_d;
      beat_data_q     <= beat_data_d;
      beat_strb_q     <= beat_strb_d;
    end
  end

  assign beat_valid_o = out_valid_q;
  assign beat_data_o  = beat_data_q;
  assign beat_strb_o  = beat_strb_q;

endmodule

// File: doc/redmule_mx_fp16_packer.md
# redmule_mx_fp16_packer

Packs the scalar FP16 element stream produced by `redmule_mx_decoder` into DATA_W-wide beats for the RedMulE engine-side streamer. It sits directly downstream of the decoder and consumes its `fp16_valid/ready/data` handshake one element per cycle. The block is double-buffered: one fill register and one output register. It sustains one element per cycle under no backpressure and supports an explicit flush that emits a zero-padded partial beat.

## Interface
- `DATA_W`, default 256: output beat width in bits; must be an integer multiple of BITW.
- `BITW`, default 16: element width in bits (FP16).
- `ELEMS`, default DATA_W/BITW (16): elements per beat; derived, must be ≥2.
- `clk_i`, in, 1: the single clock; all state updates on its rising edge.
- `rst_ni`, in, 1: synchronous, active-low reset.
- `fp16_valid_i`, in, 1: element valid from the decoder.
- `fp16_ready_o`, out, 1: packer can accept an element.
- `fp16_data_i`, in, BITW: FP16 element.
- `flush_i`, in, 1: single-cycle request to emit the current partial beat.
- `beat_valid_o`, out, 1: output beat valid.
- `beat_ready_i`, in, 1: consumer accepts the beat.
- `beat_data_o`, out, DATA_W: packed beat; lane k occupies bits [k*BITW +: BITW]; lane 0 is the first element received.
- `beat_strb_o`, out, ELEMS: per-lane valid mask; bit k set means lane k holds a real element.

## Operation
- State:
  - fill register (DATA_W bits);
  - fill count `cnt`, 0..ELEMS, $clog2(ELEMS+1) bits;
  - output register holding data, strb and `out_valid`;
  - `flush_pending` flag.
- Slot free: `slot_free = !out_valid || beat_ready_i`.
- Accept: occurs when `fp16_valid_i && fp16_ready_o`. The element is written to lane `cnt`.
- Ready: `fp16_ready_o = rst_ni && (cnt < ELEMS) && !flush_pending`. It has no combinational path from `beat_ready_i`.
- Accept of the ELEMSth element (cnt == ELEMS-1):
  - If `slot_free`: the assembled beat, including this element, loads the output register with strb all-ones; `cnt` becomes 0.
  - Otherwise: `cnt` becomes ELEMS, which stalls input.
- Full fill (cnt == ELEMS) and `slot_free`: fill transfers to output with strb all-ones; `cnt` becomes 0.
- Flush:
  - `flush_i` sets `flush_pending`. An element accepted in the same cycle as `flush_i` is included in the flushed beat.
  - With `flush_pending`, 0 < cnt < ELEMS and `slot_free`: fill transfers with lanes ≥ cnt forced to zero and strb = (1<<cnt)-1. `cnt` becomes 0 and `flush_pending` clears.
  - With `flush_pending` and cnt == 0: `flush_pending` clears and no beat is emitted.
  - With `flush_pending` and cnt == ELEMS: the normal full transfer happens first; pending then clears on the next cycle with cnt == 0.
  - `flush_i` while already pending has no additional effect.
- Output hold: the output register holds data and strb stable while `beat_valid_o && !beat_ready_i`. When a transfer loads it on the same edge the old beat is consumed, `out_valid` stays 1 (back-to-back beats).
- The fill register is not cleared on transfer. Unused lanes are zeroed only at flush transfer.

## Timing
- Reset, when rst_ni is low at a rising edge:
  - `cnt` = 0, `flush_pending` = 0, `out_valid` = 0;
  - `beat_valid_o` = 0, `beat_data_o` = 0, `beat_strb_o` = 0;
  - `fp16_ready_o` = 0 while rst_ni is low, and 1 in the first cycle after release.
  - Reset mid-beat discards all partial and pending data.
- Latency: `beat_valid_o` rises the cycle after the handshake of the last element, or after the flush transfer edge.
- Throughput:
  - With `beat_ready_i` held 1: one element per cycle, no bubbles.
  - Under stall: up to 2*ELEMS elements are buffered (one output beat plus one full fill) before `fp16_ready_o` drops.
- After a stall releases, `fp16_ready_o` rises the cycle after the full-fill transfer edge.
- Flush with cnt > 0 and a free slot: the beat appears 2 cycles after `flush_i` (edge 1 latches pending, edge 2 transfers). If `flush_i` coincides with a transfer-eligible state, pending is still taken first.

## Test plan
- **Full beat, no stall:** `beat_ready_i`=1; push 16 elements 16'h3C00+k back-to-back. Expect one beat with lane k = 3C00+k and strb 16'hFFFF. `beat_valid_o` is high exactly one cycle, starting the cycle after the 16th handshake. `fp16_ready_o` never drops.
- **Backpressure:** `beat_ready_i`=0; push 32 elements 16'h0001..16'h0020. `fp16_ready_o` drops after the 32nd. Raise `beat_ready_i`; expect beats lanes 0x0001..0x0010, then 0x0011..0x0020. `fp16_ready_o` returns to 1 the cycle after the second beat loads.
- **Partial flush:** push 5 elements 16'hAAA0..16'hAAA4, then pulse `flush_i`. Expect a beat with strb 16'h001F, lanes 0–4 as pushed, and lanes 5–15 = 0. `fp16_ready_o` is low while pending.
- **Empty flush:** pulse `flush_i` with cnt 0. Expect no `beat_valid_o`, and `fp16_ready_o` back to 1 after one cycle.
- **Reset mid-fill:** push 7 elements, then hold `rst_ni`=0 for 1 cycle. Expect all outputs 0. Then push 16 elements 16'h4000+k; expect a single clean beat starting at lane 0 with strb 16'hFFFF.
- **Random stall:** stream 48 elements with `beat_ready_i` toggling every cycle. Expect exactly 3 beats, in order, with no loss or duplication, and data stable during every stall.
